// File: rtl/idct8_chen_ts.sv
`default_nettype none
// ============================================================================
// Module   : idct8_chen_ts
// Purpose  : Time-shared 8-point inverse DCT using the Chen even/odd split.
//            One signed multiplier is reused for 22 products (6 even, 16 odd)
//            accumulated at full precision. The final butterflies, rounding
//            and saturation are registered in FIN.
// Ports    : clk, rst_n (async, active-low)
//            in_valid/in_ready, in0..in7   : coefficient vector X0..X7
//            out_valid/out_ready, out0..out7 : sample vector x0..x7
//            sat_flag (only with IDCT8_SAT_FLAG_EN) : some output was clipped
// Options  : `define IDCT8_SAT_FLAG_EN to add the sat_flag output port.
// Revision : 1.0 - initial release
// ============================================================================
module idct8_chen_ts #(
  parameter int IN_W    = 32,
  parameter int OUT_W   = 32,
  parameter int CONST_W = 12,
  parameter int FRAC    = 8,
  parameter int C1 = 126, parameter int C2 = 118, parameter int C3 = 106,
  parameter int C4 = 91,  parameter int C5 = 71,  parameter int C6 = 49,
  parameter int C7 = 25
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [IN_W-1:0]  in0, in1, in2, in3, in4, in5, in6, in7,
  output logic                    out_valid,
  input  logic                    out_ready,
`ifdef IDCT8_SAT_FLAG_EN
  output logic                    sat_flag,
`endif
  output logic signed [OUT_W-1:0] out0, out1, out2, out3, out4, out5, out6, out7
);

  localparam int OPW = IN_W + 1;           // operand may be X0+/-X4
  localparam int PW  = CONST_W + OPW;      // exact product width
  localparam int AW  = IN_W + CONST_W + 4; // accumulator / butterfly width

  localparam logic signed [CONST_W-1:0] K1 = CONST_W'(C1);
  localparam logic signed [CONST_W-1:0] K2 = CONST_W'(C2);
  localparam logic signed [CONST_W-1:0] K3 = CONST_W'(C3);
  localparam logic signed [CONST_W-1:0] K4 = CONST_W'(C4);
  localparam logic signed [CONST_W-1:0] K5 = CONST_W'(C5);
  localparam logic signed [CONST_W-1:0] K6 = CONST_W'(C6);
  localparam logic signed [CONST_W-1:0] K7 = CONST_W'(C7);

  localparam logic signed [AW-1:0] RND  = AW'(2 ** (FRAC - 1));
  localparam logic signed [AW-1:0] OMAX = {{(AW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [AW-1:0] OMIN = ~OMAX;

  typedef enum logic [2:0] {S_IDLE, S_EVEN, S_ODD, S_FIN, S_OUT} state_t;

  state_t                    state;
  logic [4:0]                step;
  logic signed [IN_W-1:0]    xr   [8];
  logic signed [AW-1:0]      acc  [8];  // 0..3 = a,b,c,d ; 4..7 = o0..o3
  logic signed [OUT_W-1:0]   outr [8];

  // ---------------- product schedule (one multiply per cycle) --------------
  logic signed [CONST_W-1:0] coef;
  logic signed [OPW-1:0]     opnd;
  logic                      neg;
  logic [2:0]                idx;
  logic signed [PW-1:0]      prod;
  logic signed [AW-1:0]      term;

  function automatic logic signed [OPW-1:0] ext(input logic signed [IN_W-1:0] v);
    return {v[IN_W-1], v};
  endfunction

  always_comb begin
    coef = K1;
    opnd = ext(xr[1]);
    neg  = 1'b0;
    idx  = 3'd4;
    case (step)
      5'd0:  begin coef = K4; opnd = ext(xr[0]) + ext(xr[4]); idx = 3'd0; end
      5'd1:  begin coef = K4; opnd = ext(xr[0]) - ext(xr[4]); idx = 3'd1; end
      5'd2:  begin coef = K2; opnd = ext(xr[2]); idx = 3'd2; end
      5'd3:  begin coef = K6; opnd = ext(xr[6]); idx = 3'd2; end
      5'd4:  begin coef = K6; opnd = ext(xr[2]); idx = 3'd3; end
      5'd5:  begin coef = K2; opnd = ext(xr[6]); idx = 3'd3; neg = 1'b1; end
      // o0 = C1X1 + C3X3 + C5X5 + C7X7
      5'd6:  begin coef = K1; opnd = ext(xr[1]); idx = 3'd4; end
      5'd7:  begin coef = K3; opnd = ext(xr[3]); idx = 3'd4; end
      5'd8:  begin coef = K5; opnd = ext(xr[5]); idx = 3'd4; end
      5'd9:  begin coef = K7; opnd = ext(xr[7]); idx = 3'd4; end
      // o1 = C3X1 - C7X3 - C1X5 - C5X7
      5'd10: begin coef = K3; opnd = ext(xr[1]); idx = 3'd5; end
      5'd11: begin coef = K7; opnd = ext(xr[3]); idx = 3'd5; neg = 1'b1; end
      5'd12: begin coef = K1; opnd = ext(xr[5]); idx = 3'd5; neg = 1'b1; end
      5'd13: begin coef = K5; opnd = ext(xr[7]); idx = 3'd5; neg = 1'b1; end
      // o2 = C5X1 - C1X3 + C7X5 + C3X7
      5'd14: begin coef = K5; opnd = ext(xr[1]); idx = 3'd6; end
      5'd15: begin coef = K1; opnd = ext(xr[3]); idx = 3'd6; neg = 1'b1; end
      5'd16: begin coef = K7; opnd = ext(xr[5]); idx = 3'd6; end
      5'd17: begin coef = K3; opnd = ext(xr[7]); idx = 3'd6; end
      // o3 = C7X1 - C5X3 + C3X5 - C1X7
      5'd18: begin coef = K7; opnd = ext(xr[1]); idx = 3'd7; end
      5'd19: begin coef = K5; opnd = ext(xr[3]); idx = 3'd7; neg = 1'b1; end
      5'd20: begin coef = K3; opnd = ext(xr[5]); idx = 3'd7; end
      5'd21: begin coef = K1; opnd = ext(xr[7]); idx = 3'd7; neg = 1'b1; end
      default: ;
    endcase
  end

  // Both operands widened first so the product is formed at its exact width.
  assign prod = PW'(coef) * PW'(opnd);
  assign term = neg ? -AW'(prod) : AW'(prod);

  // ---------------- butterflies, rounding, saturation ----------------------
  logic signed [AW-1:0]    e   [4];
  logic signed [AW-1:0]    v   [8];
  logic signed [AW-1:0]    r   [8];
  logic signed [OUT_W-1:0] res [8];
  logic [7:0]              clip;

  always_comb begin
    e[0] = acc[0] + acc[2];
    e[1] = acc[1] + acc[3];
    e[2] = acc[1] - acc[3];
    e[3] = acc[0] - acc[2];
    for (int n = 0; n < 4; n++) begin
      v[n]     = e[n] + acc[4+n];
      v[7-n]   = e[n] - acc[4+n];
    end
    for (int i = 0; i < 8; i++) begin
      r[i]    = (v[i] + RND) >>> FRAC;
      clip[i] = (r[i] > OMAX) || (r[i] < OMIN);
      if (r[i] > OMAX)      res[i] = {1'b0, {(OUT_W-1){1'b1}}};
      else if (r[i] < OMIN) res[i] = {1'b1, {(OUT_W-1){1'b0}}};
      else                  res[i] = r[i][OUT_W-1:0];
    end
  end

  // ---------------- control and datapath registers -------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      step      <= 5'd0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
`ifdef IDCT8_SAT_FLAG_EN
      sat_flag  <= 1'b0;
`endif
      for (int i = 0; i < 8; i++) begin
        xr[i]   <= '0;
        acc[i]  <= '0;
        outr[i] <= '0;
      end
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            xr[0] <= in0; xr[1] <= in1; xr[2] <= in2; xr[3] <= in3;
            xr[4] <= in4; xr[5] <= in5; xr[6] <= in6; xr[7] <= in7;
            for (int i = 0; i < 8; i++) acc[i] <= '0;
            step     <= 5'd0;
            in_ready <= 1'b0;
            state    <= S_EVEN;
          end
        end
        S_EVEN, S_ODD: begin
          acc[idx] <= acc[idx] + term;
          step     <= step + 5'd1;
          if (step == 5'd5) state <= S_ODD;
          if (step == 5'd21) begin
            step  <= 5'd0;
            state <= S_FIN;
          end
        end
        S_FIN: begin
          for (int i = 0; i < 8; i++) outr[i] <= res[i];
`ifdef IDCT8_SAT_FLAG_EN
          sat_flag  <= |clip;
`endif
          out_valid <= 1'b1;
          state     <= S_OUT;
        end
        S_OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
`ifdef IDCT8_SAT_FLAG_EN
            sat_flag  <= 1'b0;
`endif
            in_ready  <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifndef IDCT8_SAT_FLAG_EN
  // Clipping still happens in res; only the indication is dropped.
  logic unused_clip;
  assign unused_clip = ^clip;
`endif

  assign out0 = outr[0]; assign out1 = outr[1];
  assign out2 = outr[2]; assign out3 = outr[3];
  assign out4 = outr[4]; assign out5 = outr[5];
  assign out6 = outr[6]; assign out7 = outr[7];

endmodule
`default_nettype wire
